clk_div_bank: RTL
=================

Name: clk_div_bank

Overview:
- Parametrised multi-channel clock divider. Runs entirely in the clk50m domain.
- Each channel produces a 50%-duty divided square wave (div_out) and a one-cycle clock-enable strobe (tick).
- Divisors are reloadable at run time through a write port. A new divisor takes effect only at the channel's next terminal count, so there is no glitch.
- Sits at the top of the design, feeding the VGA pixel, game-tick and timer logic. Downstream logic should use tick as an enable, not as a clock.

Parameters:
- NUM_CH, 3, number of independent divider channels.
- CNT_W, 25, counter and limit width per channel.
- CH_W, 2, width of cfg_ch. Must satisfy 2^CH_W >= NUM_CH.
- LIM_INIT, {25'd24999999, 25'd500000, 25'd1}, packed NUM_CH*CNT_W reset limits. Channel 0 occupies the LSBs.

Ports:
- clk50m  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- ch_en  in  NUM_CH  per-channel run enable.
- cfg_wr  in  1  one-cycle write strobe for a new limit.
- cfg_ch  in  CH_W  target channel index.
- cfg_lim  in  CNT_W  new terminal-count value.
- cfg_pend  out  NUM_CH  a limit is pending for the channel.
- cfg_ack  out  NUM_CH  one-cycle pulse when a pending limit has been applied.
- div_out  out  NUM_CH  divided square wave, f = 50 MHz / (2*(lim+1)).
- tick  out  NUM_CH  one-cycle strobe, f = 50 MHz / (lim+1).

Behaviour:
- Clocking and reset
  - Single clock domain, clk50m. Clock domain crossing is out of scope.
  - rst is asynchronous and active-high.
  - Reset values: cnt[i]=0, lim[i]=LIM_INIT slice i, pend_val[i]=0, cfg_pend=0, cfg_ack=0, div_out=0, tick=0.
  - Reset asserted mid-operation discards any pending write.
- Per channel, ch_en[i]=1
  - cnt counts 0..lim.
  - Terminal count (cnt==lim): cnt<=0, div_out toggles, tick=1 for exactly that one registered cycle.
  - Otherwise cnt<=cnt+1 and tick=0.
- Latency and outputs
  - All outputs are registered.
  - After reset release with ch_en high, the first tick appears lim+1 cycles later, and div_out rises at the same edge.
- lim=0: div_out toggles every cycle and tick stays high continuously.
- ch_en[i]=0
  - cnt and div_out hold their values; tick=0.
  - Re-enabling resumes from the held cnt.
- Configuration writes
  - cfg_wr with cfg_ch<NUM_CH: pend_val[cfg_ch]<=cfg_lim and cfg_pend[cfg_ch]<=1 on the next edge.
  - cfg_ch>=NUM_CH: the write is ignored and no flag changes.
- Applying a pending limit
  - Channel enabled: applied at the next terminal count. On that edge lim<=pend_val, cnt<=0, div_out toggles and tick fires. The period that follows uses the new lim.
  - Channel disabled: applied on the first edge at which cfg_pend is set. cnt<=0; div_out holds.
  - On application: cfg_pend[i]<=0 and cfg_ack[i] pulses for one cycle after the applying edge.
- Boundary cases
  - Write while pending: overwrites pend_val; only one ack is produced.
  - Write in the same cycle as the channel's terminal count: the terminal count uses the old lim. The new value is pending and applies at the following terminal count.
  - Write in the same cycle as an application: the new write wins. cfg_pend stays 1 and no ack is produced for the overwritten value.
- Counter width: counter arithmetic is CNT_W wide and the counter never exceeds lim.
- Channels are fully independent.

Optional Feature:
- Macro: CLKDIV_SYNC_EN.
- Defined:
  - Adds input port sync_in (1 bit).
  - sync_in=1 on an edge: every channel gets cnt<=0, div_out<=0, tick<=0, and any pending limit is applied with its ack.
  - sync_in has priority over terminal-count and enable logic, so all channels become phase-aligned on release.
- Undefined: sync_in is absent and no alignment logic is built.

Test Plan:
- Reset/run: LIM_INIT={10'd9,10'd4,10'd1}, CNT_W=10, all ch_en=1, release rst -> tick0 every 2 cycles, tick1 every 5, tick2 every 10. div_out periods are 4, 10 and 20 cycles; all outputs 0 during reset.
- Glitch-free reload: ch1 running lim=4, write cfg_lim=2 at cnt=1 -> cfg_pend[1]=1. The remaining period still completes at lim=4; the next periods are 3 cycles; cfg_ack[1] pulses once.
- Same-cycle collision: write ch0 cfg_lim=3 exactly at ch0 terminal count -> that tick is unaffected, the next period is 2 cycles, then 4-cycle periods, with a single ack.
- Disabled reload and hold: ch2 ch_en=0 mid-count -> cnt and div_out frozen, tick=0. Write cfg_lim=0 -> ack next cycle, cnt=0. Re-enable -> tick2 held high and div_out toggles every cycle.
- Invalid and overwrite: cfg_ch=3 write -> no state change. Two writes to ch1 (6, then 7) before terminal count -> lim=7 applied, one ack.
- CLKDIV_SYNC_EN: with the macro defined, pulse sync_in at arbitrary phases -> next cycle all cnt=0, div_out=0. Subsequent ticks coincide at multiples of the LCM of the periods.

Source files
------------

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_bank
// Purpose  : Multi-channel clock-enable / square-wave divider with glitch-free
//            run-time limit reload. Optional macro CLKDIV_SYNC_EN adds sync_in.
// Revision : 1.0  initial release
// ============================================================================
module clk_div_bank #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 25,
  parameter int CH_W   = 2,
  parameter logic [NUM_CH*CNT_W-1:0] LIM_INIT = {25'd24999999, 25'd500000, 25'd1}
) (
  input  logic              clk50m,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_lim,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_in,
`endif
  output logic [NUM_CH-1:0] cfg_pend,
  output logic [NUM_CH-1:0] cfg_ack,
  output logic [NUM_CH-1:0] div_out,
  output logic [NUM_CH-1:0] tick
);

  logic sync_req;
`ifdef CLKDIV_SYNC_EN
  assign sync_req = sync_in;
`else
  assign sync_req = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] lim;
      logic [CNT_W-1:0] pend_val;
      logic             pend;
      logic             ack;
      logic             div_q;
      logic             tick_q;
      logic             wr_hit;
      logic             at_tc;
      logic             apply;

      assign wr_hit = cfg_wr && (cfg_ch == CH_W'(gi));
      assign at_tc  = (cnt == lim);
      // A write landing on the applying edge supersedes the older pending value.
      assign apply  = pend && !wr_hit && (sync_req || !ch_en[gi] || at_tc);

      always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
          cnt      <= '0;
          lim      <= LIM_INIT[gi*CNT_W +: CNT_W];
          pend_val <= '0;
          pend     <= 1'b0;
          ack      <= 1'b0;
          div_q    <= 1'b0;
          tick_q   <= 1'b0;
        end else begin
          ack    <= apply;
          tick_q <= 1'b0;

          if (wr_hit) begin
            pend_val <= cfg_lim;
            pend     <= 1'b1;
          end else if (apply) begin
            pend     <= 1'b0;
          end

          if (apply) begin
            lim <= pend_val;
          end

          if (sync_req) begin
            cnt   <= '0;
            div_q <= 1'b0;
          end else if (ch_en[gi]) begin
            if (at_tc) begin
              cnt    <= '0;
              div_q  <= ~div_q;
              tick_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (apply) begin
            cnt <= '0;
          end
        end
      end

      assign cfg_pend[gi] = pend;
      assign cfg_ack[gi]  = ack;
      assign div_out[gi]  = div_q;
      assign tick[gi]     = tick_q;
    end
  endgenerate

endmodule
`default_nettype wire
